// File: rtl/fwd_pkg.sv
// Shared constants and slot record for the forwarding hazard tracker.
package fwd_pkg;

    localparam int TRK_RD_W  = 8;
    localparam int TRK_LAT_W = 3;

    localparam int FWD_SEL_RF    = 0;
    localparam int FWD_SEL_EXMEM = 1;
    localparam int FWD_SEL_MEMWB = 2;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    // rd is held zero-extended to the widest supported register address.
    typedef struct packed {
        logic                 valid;
        logic                 wb;
        logic [TRK_RD_W-1:0]  rd;
        logic [TRK_LAT_W-1:0] lat;
    } trk_slot_t;

    // A latency of zero behaves like a single-cycle ALU result.
    function automatic logic [TRK_LAT_W-1:0] norm_lat(input logic [TRK_LAT_W-1:0] lat);
        return (lat == '0) ? TRK_LAT_W'(1) : lat;
    endfunction

endpackage

// File: rtl/fwd_src_lookup.sv
// Per-operand priority match of one source register against the tracked slots.
module fwd_src_lookup
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH)
) (
    input  logic [REG_AW-1:0]      src_i,
    input  logic                   used_i,
    input  trk_slot_t [DEPTH-1:1]  slots_i,
    output logic [SEL_W-1:0]       sel_o,
    output logic                   hazard_o
);

    logic                 match_s;
    logic [TRK_LAT_W-1:0] match_dist_s;
    logic [TRK_LAT_W-1:0] match_lat_s;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        match_s      = 1'b0;
        match_dist_s = '0;
        match_lat_s  = '0;
        for (int d = DEPTH - 1; d >= 1; d--) begin
            if (slots_i[d].valid && slots_i[d].wb && (slots_i[d].rd == TRK_RD_W'(src_i))) begin
                match_s      = 1'b1;
                match_dist_s = TRK_LAT_W'(d);
                match_lat_s  = slots_i[d].lat;
            end
        end
    end

    always_comb begin
        sel_o    = '0;
        hazard_o = 1'b0;
        if (used_i && (src_i != '0) && match_s) begin
            if (match_lat_s > match_dist_s) begin
                hazard_o = 1'b1;
            end else begin
                sel_o = match_dist_s[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Tracks in-flight register writers, resolves operand forwarding at decode,
// and stalls decode while the nearest producer's result is not yet available.
module fwd_hazard_tracker
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = $clog2(DEPTH),
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]        id_src_used_i,
    input  logic                      id_wb_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic [SEL_W-1:0]          id_lat_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    // The WB slot never forwards, so only slots 1..DEPTH-1 are held;
    // an entry leaving slot DEPTH-1 simply retires through WB.
    trk_slot_t [DEPTH-1:1]     slots_q, slots_d;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC*SEL_W-1:0]  sel_s;
    logic [NUM_SRC-1:0]        hazard_s;
    logic                      issue_s;
    trk_slot_t                 new_slot_s;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lookup
        fwd_src_lookup #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_lookup (
            .src_i    (id_src_i[k*REG_AW +: REG_AW]),
            .used_i   (id_src_used_i[k]),
            .slots_i  (slots_q),
            .sel_o    (sel_s[k*SEL_W +: SEL_W]),
            .hazard_o (hazard_s[k])
        );
    end

    // Flush overrides any hazard on the squashed instruction.
    assign stall_o = id_valid_i && !flush_i && (|hazard_s);
    assign issue_s = id_valid_i && !flush_i && !stall_o;

    always_comb begin
        new_slot_s.valid = 1'b1;
        new_slot_s.wb    = id_wb_i;
        new_slot_s.rd    = TRK_RD_W'(id_rd_i);
        new_slot_s.lat   = norm_lat(TRK_LAT_W'(id_lat_i));

        slots_d[1] = issue_s ? new_slot_s : '0;
        for (int j = 2; j <= DEPTH - 1; j++) begin
            slots_d[j] = slots_q[j-1];
        end

        fwd_sel_d = issue_s ? sel_s : '0;

        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots_q     <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            slots_q     <= slots_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel_o   = fwd_sel_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed plus randomized bench for fwd_hazard_tracker against a queue-based history model.
module tb_fwd_hazard_tracker;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int SEL_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst_i = 1'b1;
    logic                      id_valid_i = 1'b0;
    logic [NUM_SRC*REG_AW-1:0] id_src_i = '0;
    logic [NUM_SRC-1:0]        id_src_used_i = '0;
    logic                      id_wb_i = 1'b0;
    logic [REG_AW-1:0]         id_rd_i = '0;
    logic [SEL_W-1:0]          id_lat_i = '0;
    logic                      flush_i = 1'b0;
    logic                      stall_o, stall_sat;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o, fwd_sat;
    logic [15:0]               stall_cnt_o;
    logic [1:0]                cnt_sat;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit v;
        bit wb;
        int rd;
        int lat;
    } ent_t;

    ent_t hist[$];
    logic [NUM_SRC*SEL_W-1:0] mfwd = '0;
    int                       mcnt = 0;

    always #5 clk = ~clk;

    fwd_hazard_tracker #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_src_i(id_src_i),
        .id_src_used_i(id_src_used_i), .id_wb_i(id_wb_i), .id_rd_i(id_rd_i), .id_lat_i(id_lat_i),
        .flush_i(flush_i), .stall_o(stall_o), .fwd_sel_o(fwd_sel_o), .stall_cnt_o(stall_cnt_o)
    );

    fwd_hazard_tracker #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_src_i(id_src_i),
        .id_src_used_i(id_src_used_i), .id_wb_i(id_wb_i), .id_rd_i(id_rd_i), .id_lat_i(id_lat_i),
        .flush_i(flush_i), .stall_o(stall_sat), .fwd_sel_o(fwd_sat), .stall_cnt_o(cnt_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One decode cycle: drive, check stall against the model, clock, check registered outputs.
    task automatic step(input logic v, input logic [REG_AW-1:0] s0, input logic [REG_AW-1:0] s1,
                        input logic [1:0] used, input logic wb, input logic [REG_AW-1:0] rd,
                        input int lat, input logic fl, input logic rs);
        logic [NUM_SRC*SEL_W-1:0] esel;
        bit hz, estall, issue;
        ent_t e;
        @(negedge clk);
        rst_i = rs; id_valid_i = v; id_src_i = {s1, s0}; id_src_used_i = used;
        id_wb_i = wb; id_rd_i = rd; id_lat_i = SEL_W'(lat); flush_i = fl;
        tests++;
        assert (!v || (lat < DEPTH)) else begin
            fails++;
            $error("FAIL lat_legal observed=%0d expected=<%0d", lat, DEPTH);
        end
        #1;
        esel = '0;
        hz = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int src;
            bit found;
            src = (k == 0) ? int'(s0) : int'(s1);
            found = 1'b0;
            if (used[k] && src != 0) begin
                for (int d = 1; d < DEPTH; d++) begin
                    if (!found && (d - 1) < hist.size() && hist[d-1].v && hist[d-1].wb && hist[d-1].rd == src) begin
                        int l;
                        found = 1'b1;
                        l = (hist[d-1].lat == 0) ? 1 : hist[d-1].lat;
                        if (l > d) hz = 1'b1;
                        else esel[k*SEL_W +: SEL_W] = SEL_W'(d);
                    end
                end
            end
        end
        estall = v && !fl && hz;
        issue  = v && !fl && !estall;
        chk("stall", {31'd0, stall_o}, {31'd0, estall});
        chk("stall_sat_inst", {31'd0, stall_sat}, {31'd0, estall});
        @(posedge clk);
        if (rs) begin
            hist.delete();
            mfwd = '0;
            mcnt = 0;
        end else begin
            e.v = issue; e.wb = wb; e.rd = int'(rd); e.lat = lat;
            hist.push_front(e);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            mfwd = issue ? esel : '0;
            mcnt = mcnt + (estall ? 1 : 0);
        end
        #1;
        chk("fwd_sel", 32'(fwd_sel_o), 32'(mfwd));
        chk("fwd_sel_sat_inst", 32'(fwd_sat), 32'(mfwd));
        chk("stall_cnt", 32'(stall_cnt_o), (mcnt > 65535) ? 32'd65535 : 32'(mcnt));
        chk("stall_cnt_sat", 32'(cnt_sat), (mcnt > 3) ? 32'd3 : 32'(mcnt));
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1, 1'b0, 1'b1);
        chk("reset_fwd", 32'(fwd_sel_o), 32'd0);
        chk("reset_cnt", 32'(stall_cnt_o), 32'd0);

        // ALU back-to-back: add r3 then sub r6 <- r3
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 2'b01, 1'b1, 5'd6, 1, 1'b0, 1'b0);
        chk("b2b_stall", {31'd0, stall_o}, 32'd0);
        chk("b2b_sel", 32'(fwd_sel_o[1:0]), 32'd1);

        // Distance 2 and 3
        nops(3);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1, 1'b0, 1'b0);
        nops(1);
        step(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        chk("dist2_sel", 32'(fwd_sel_o[1:0]), 32'd2);
        nops(3);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1, 1'b0, 1'b0);
        nops(2);
        step(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        chk("dist3_sel", 32'(fwd_sel_o[1:0]), 32'd0);

        // Load-use: one stall then forward from MEM/WB
        nops(3);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2, 1'b0, 1'b0);
        step(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        chk("lu_bubble", 32'(fwd_sel_o), 32'd0);
        step(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        chk("lu_sel", 32'(fwd_sel_o[1:0]), 32'd2);
        chk("lu_cnt", 32'(stall_cnt_o), 32'd1);

        // Youngest producer wins on both operands; r0 never forwards
        nops(3);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1, 1'b0, 1'b0);
        step(1'b1, 5'd5, 5'd5, 2'b11, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        chk("dual_sel", 32'(fwd_sel_o), 32'h5);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 2, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        chk("r0_sel", 32'(fwd_sel_o), 32'd0);

        // Flush during a load-use hazard
        nops(3);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2, 1'b0, 1'b0);
        step(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 1, 1'b1, 1'b0);
        chk("flush_cnt", 32'(stall_cnt_o), 32'd1);

        // Reset with slots full discards every entry
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd1, 1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd2, 1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1, 1'b0, 1'b1);
        step(1'b1, 5'd3, 5'd2, 2'b11, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        chk("rst_stale_sel", 32'(fwd_sel_o), 32'd0);

        // Five load-use stalls saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            nops(2);
            step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2, 1'b0, 1'b0);
            step(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 1, 1'b0, 1'b0);
            step(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 1, 1'b0, 1'b0);
        end
        chk("sat_hold", 32'(cnt_sat), 32'd3);
        chk("cnt16_five", 32'(stall_cnt_o), 32'd5);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH - 1)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
